// File: rtl/load_store_sequencer.sv
// Memory-stage load/store sequencer: turns one byte-addressed access into one or two word accesses with lane enables.
// Build option MISALIGN_SPLIT_EN: when defined, word-crossing accesses are split; otherwise they are rejected with MisalignErr.
module load_store_sequencer (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        ReqValid,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        ReqReady,
  output logic        StallM,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        MisalignErr,
  output logic        MemReq,
  output logic [29:0] MemAddr,
  output logic [3:0]  MemWE,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData
);

  // Handshake: a request is taken on a rising edge with ReqValid & ReqReady; the
  // memory side holds MemReq/MemAddr/MemWE/MemWData steady until the edge that sees MemAck.
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      state;
  logic [2:0]  req_nbytes;
  logic [3:0]  req_mask;
  logic        req_cross;
  logic [3:0]  req_we_lo;
  logic [31:0] req_wdata_lo;

  logic        op_write;
  logic [1:0]  op_size;
  logic        op_signed;
  logic [1:0]  op_off;
  logic [31:0] lo_buf;
  logic [31:0] hi_word;

  always_comb begin
    req_nbytes = 3'd4;
    req_mask   = 4'b1111;
    case (ReqSize)
      2'b00: begin req_nbytes = 3'd1; req_mask = 4'b0001; end
      2'b01: begin req_nbytes = 3'd2; req_mask = 4'b0011; end
      default: ;
    endcase
  end

  assign req_cross = ({2'b00, ReqAddr[1:0]} + {1'b0, req_nbytes}) > 4'd4;

`ifdef MISALIGN_SPLIT_EN
  logic [7:0]  mask_wide;
  logic [63:0] data_wide;
  logic        op_cross;
  logic [3:0]  we_hi;
  logic [31:0] wdata_hi;
  logic [31:0] hi_buf;

  assign mask_wide    = {4'b0000, req_mask} << ReqAddr[1:0];
  assign data_wide    = {32'b0, ReqWData} << {ReqAddr[1:0], 3'b000};
  assign req_we_lo    = mask_wide[3:0];
  assign req_wdata_lo = data_wide[31:0];
  assign hi_word      = hi_buf;
  assign MisalignErr  = 1'b0;
`else
  logic err_q;

  assign req_we_lo    = 4'({4'b0000, req_mask} << ReqAddr[1:0]);
  assign req_wdata_lo = ReqWData << {ReqAddr[1:0], 3'b000};
  assign hi_word      = 32'b0;
  assign MisalignErr  = err_q;
`endif

  function automatic logic [31:0] merge(input logic [63:0] words, input logic [1:0] off,
                                        input logic [1:0] size, input logic sgn);
    logic [31:0] raw;
    raw = 32'(words >> {off, 3'b000});
    case (size)
      2'b00:   merge = {{24{sgn & raw[7]}}, raw[7:0]};
      2'b01:   merge = {{16{sgn & raw[15]}}, raw[15:0]};
      default: merge = raw;
    endcase
  endfunction

  assign ReqReady = (state == IDLE);
  assign StallM   = ~ReqReady;
  assign RespData = (RespValid && !op_write && !MisalignErr)
                    ? merge({hi_word, lo_buf}, op_off, op_size, op_signed) : 32'b0;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      RespValid <= 1'b0;
      MemReq    <= 1'b0;
      MemAddr   <= '0;
      MemWE     <= '0;
      MemWData  <= '0;
      op_write  <= 1'b0;
      op_size   <= '0;
      op_signed <= 1'b0;
      op_off    <= '0;
      lo_buf    <= '0;
`ifdef MISALIGN_SPLIT_EN
      op_cross  <= 1'b0;
      we_hi     <= '0;
      wdata_hi  <= '0;
      hi_buf    <= '0;
`else
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid) begin
            op_write  <= ReqWrite;
            op_size   <= ReqSize;
            op_signed <= ReqSigned;
            op_off    <= ReqAddr[1:0];
`ifndef MISALIGN_SPLIT_EN
            if (req_cross) begin
              // Rejected crossing access: answer straight away without touching memory.
              state     <= RESP;
              RespValid <= 1'b1;
              err_q     <= 1'b1;
            end else
`endif
            begin
              state    <= ACC0;
              MemReq   <= 1'b1;
              MemAddr  <= ReqAddr[31:2];
              MemWE    <= ReqWrite ? req_we_lo : 4'b0000;
              MemWData <= req_wdata_lo;
`ifdef MISALIGN_SPLIT_EN
              op_cross <= req_cross;
              we_hi    <= mask_wide[7:4];
              wdata_hi <= data_wide[63:32];
`endif
            end
          end
        end
        ACC0: begin
          if (MemAck) begin
            lo_buf <= MemRData;
`ifdef MISALIGN_SPLIT_EN
            if (op_cross) begin
              state    <= ACC1;
              MemAddr  <= MemAddr + 30'd1;
              MemWE    <= op_write ? we_hi : 4'b0000;
              MemWData <= wdata_hi;
            end else
`endif
            begin
              state     <= RESP;
              RespValid <= 1'b1;
              MemReq    <= 1'b0;
              MemAddr   <= '0;
              MemWE     <= '0;
              MemWData  <= '0;
            end
          end
        end
`ifdef MISALIGN_SPLIT_EN
        ACC1: begin
          if (MemAck) begin
            hi_buf    <= MemRData;
            state     <= RESP;
            RespValid <= 1'b1;
            MemReq    <= 1'b0;
            MemAddr   <= '0;
            MemWE     <= '0;
            MemWData  <= '0;
          end
        end
`endif
        RESP: begin
          state     <= IDLE;
          RespValid <= 1'b0;
`ifndef MISALIGN_SPLIT_EN
          err_q     <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer: a memory model with wait states, an access scoreboard
// and a response scoreboard; expectations follow the MISALIGN_SPLIT_EN build option.
module tb_load_store_sequencer;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqWrite = 1'b0;
  logic [1:0]  ReqSize = 2'b00;
  logic        ReqSigned = 1'b0;
  logic [31:0] ReqAddr = '0;
  logic [31:0] ReqWData = '0;
  logic        MemAck = 1'b0;
  logic [31:0] MemRData = '0;
  logic        ReqReady, StallM, RespValid, MisalignErr, MemReq;
  logic [31:0] RespData, MemWData;
  logic [29:0] MemAddr;
  logic [3:0]  MemWE;

  load_store_sequencer dut (
    .CLK(CLK), .RSTn(RSTn), .ReqValid(ReqValid), .ReqWrite(ReqWrite), .ReqSize(ReqSize),
    .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqReady(ReqReady),
    .StallM(StallM), .RespValid(RespValid), .RespData(RespData), .MisalignErr(MisalignErr),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemWE(MemWE), .MemWData(MemWData),
    .MemAck(MemAck), .MemRData(MemRData)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;
  logic [32:0] exp_q[$];      // {MisalignErr, RespData}
  logic [65:0] mem_exp_q[$];  // {MemAddr, MemWE, MemWData masked to enabled lanes}
  logic [31:0] mem [logic [29:0]];
  int mem_wait = 0;
  int mem_budget = -1;        // acks still allowed; -1 means unlimited
  int wcnt = 0;
  int lat;
  logic stall1;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] we);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{we[i]}};
    return m;
  endfunction

  // Memory model: acks after mem_wait idle cycles, checks each access, applies byte writes.
  logic [31:0] rd;
  logic [65:0] mem_e;
  always @(negedge CLK) begin
    MemAck = 1'b0;
    if (!RSTn) begin
      wcnt = 0;
    end else if (MemReq && mem_budget != 0) begin
      if (wcnt >= mem_wait) begin
        wcnt = 0;
        if (mem_budget > 0) mem_budget--;
        rd = mem.exists(MemAddr) ? mem[MemAddr] : 32'b0;
        MemAck = 1'b1;
        MemRData = rd;
        if (mem_exp_q.size() == 0) begin
          fail_now("mem_unexpected_access");
        end else begin
          mem_e = mem_exp_q.pop_front();
          chk("mem_access", {MemAddr, MemWE, MemWData & lanes(MemWE)}, mem_e);
        end
        for (int i = 0; i < 4; i++) if (MemWE[i]) rd[8*i +: 8] = MemWData[8*i +: 8];
        mem[MemAddr] = rd;
      end else begin
        wcnt++;
      end
    end
  end

  // Response monitor.
  logic [32:0] resp_e;
  always @(negedge CLK) begin
    if (RSTn && RespValid) begin
      if (exp_q.size() == 0) begin
        fail_now("resp_unexpected");
      end else begin
        resp_e = exp_q.pop_front();
        chk("resp", {33'b0, MisalignErr, RespData}, {33'b0, resp_e});
      end
    end
  end

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int l, output logic st1);
    int guard;
    @(negedge CLK);
    guard = 0;
    while (!ReqReady && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (!ReqReady) fail_now("ready_timeout");
    ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sgn; ReqAddr = addr; ReqWData = wd;
    @(posedge CLK);
    l = 0;
    st1 = 1'b0;
    do begin
      @(negedge CLK);
      l++;
      if (l == 1) st1 = StallM;
    end while (!RespValid && l < 200);
    ReqValid = 1'b0;
    if (!RespValid) fail_now("resp_timeout");
  endtask

  function automatic logic [65:0] acc(input logic [29:0] a, input logic [3:0] we, input logic [31:0] d);
    return {a, we, d};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_ready_stall", {ReqReady, StallM}, 2'b10);
    chk("rst_resp", {RespValid, MisalignErr, RespData}, '0);
    chk("rst_mem", {MemReq, MemWE, MemAddr}, '0);
    chk("rst_wdata", MemWData, '0);
    RSTn = 1'b1;

    // Aligned LW, memory acks in the first request cycle.
    mem[30'h40] = 32'hDEADBEEF;
    mem_exp_q.push_back(acc(30'h40, 4'h0, 32'h0));
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, stall1);
    chk("lw_latency", lat, 2);
    chk("lw_stall", stall1, 1'b1);

    // LB / LBU from the top byte.
    mem[30'h40] = 32'h80FF0011;
    mem_exp_q.push_back(acc(30'h40, 4'h0, 32'h0));
    exp_q.push_back({1'b0, 32'hFFFFFF80});
    do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, lat, stall1);
    mem_exp_q.push_back(acc(30'h40, 4'h0, 32'h0));
    exp_q.push_back({1'b0, 32'h00000080});
    do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, lat, stall1);

    // LH at offset 1 stays within one word.
    mem[30'h40] = 32'h12348765;
    mem_exp_q.push_back(acc(30'h40, 4'h0, 32'h0));
    exp_q.push_back({1'b0, 32'h00003487});
    do_req(1'b0, 2'b01, 1'b1, 32'h101, 32'h0, lat, stall1);

    // Crossing LW and crossing SW.
    mem[30'h40] = 32'hAABBCCDD;
    mem[30'h41] = 32'h11223344;
`ifdef MISALIGN_SPLIT_EN
    mem_exp_q.push_back(acc(30'h40, 4'h0, 32'h0));
    mem_exp_q.push_back(acc(30'h41, 4'h0, 32'h0));
    exp_q.push_back({1'b0, 32'h3344AABB});
    do_req(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, lat, stall1);
    chk("cross_lw_latency", lat, 3);
    mem_exp_q.push_back(acc(30'h40, 4'b1000, 32'hBE000000));
    mem_exp_q.push_back(acc(30'h41, 4'b0111, 32'h00CAFEBA));
    exp_q.push_back({1'b0, 32'h0});
    do_req(1'b1, 2'b10, 1'b0, 32'h103, 32'hCAFEBABE, lat, stall1);
    chk("cross_sw_hi_word", mem[30'h41], 32'h11CAFEBA);
`else
    exp_q.push_back({1'b1, 32'h0});
    do_req(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, lat, stall1);
    chk("cross_lw_latency", lat, 1);
    exp_q.push_back({1'b1, 32'h0});
    do_req(1'b1, 2'b10, 1'b0, 32'h103, 32'hCAFEBABE, lat, stall1);
`endif
    mem[30'h40] = 32'hAABBCCDD;

    // SH into the upper half, SB into byte 1.
    mem_exp_q.push_back(acc(30'h40, 4'b1100, 32'h12340000));
    exp_q.push_back({1'b0, 32'h0});
    do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'h5A5A1234, lat, stall1);
    mem_exp_q.push_back(acc(30'h40, 4'b0010, 32'h0000A500));
    exp_q.push_back({1'b0, 32'h0});
    do_req(1'b1, 2'b00, 1'b0, 32'h101, 32'h000000A5, lat, stall1);

    // Loads with memory wait states and the remaining size/extension cases.
    mem_wait = 2;
    mem_exp_q.push_back(acc(30'h40, 4'h0, 32'h0));
    exp_q.push_back({1'b0, 32'h1234A5DD});
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, stall1);
    chk("wait_latency", lat, 4);
    mem_wait = 0;
    mem_exp_q.push_back(acc(30'h40, 4'h0, 32'h0));
    exp_q.push_back({1'b0, 32'h00001234});
    do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, lat, stall1);
    mem_exp_q.push_back(acc(30'h40, 4'h0, 32'h0));
    exp_q.push_back({1'b0, 32'hFFFFA5DD});
    do_req(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, lat, stall1);
    mem_exp_q.push_back(acc(30'h40, 4'h0, 32'h0));
    exp_q.push_back({1'b0, 32'h000000A5});
    do_req(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, lat, stall1);
    mem_exp_q.push_back(acc(30'h40, 4'h0, 32'h0));
    exp_q.push_back({1'b0, 32'h1234A5DD});
    do_req(1'b0, 2'b11, 1'b1, 32'h100, 32'h0, lat, stall1);

    // Crossing at the top of the address space wraps the word address.
    mem[30'h3FFFFFFF] = 32'h11223344;
    mem[30'h0] = 32'h55667788;
`ifdef MISALIGN_SPLIT_EN
    mem_exp_q.push_back(acc(30'h3FFFFFFF, 4'h0, 32'h0));
    mem_exp_q.push_back(acc(30'h0, 4'h0, 32'h0));
    exp_q.push_back({1'b0, 32'h77881122});
`else
    exp_q.push_back({1'b1, 32'h0});
`endif
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, lat, stall1);

    // Asynchronous reset while the memory withholds its ack.
    @(negedge CLK);
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqSize = 2'b10; ReqSigned = 1'b0;
`ifdef MISALIGN_SPLIT_EN
    mem_budget = 1;
    mem_exp_q.push_back(acc(30'h40, 4'h0, 32'h0));
    ReqAddr = 32'h102;
`else
    mem_budget = 0;
    ReqAddr = 32'h100;
`endif
    @(posedge CLK);
    repeat (4) @(negedge CLK);
`ifdef MISALIGN_SPLIT_EN
    chk("stuck_acc", {MemReq, MemAddr}, {1'b1, 30'h41});
`else
    chk("stuck_acc", {MemReq, MemAddr}, {1'b1, 30'h40});
`endif
    RSTn = 1'b0;
    #1;
    chk("arst_ready_stall", {ReqReady, StallM}, 2'b10);
    chk("arst_mem", {MemReq, MemWE, MemAddr}, '0);
    chk("arst_resp", {RespValid, MisalignErr, RespData, MemWData}, '0);
    ReqValid = 1'b0;
    mem_budget = -1;
    @(negedge CLK);
    RSTn = 1'b1;

    mem_exp_q.push_back(acc(30'h40, 4'h0, 32'h0));
    exp_q.push_back({1'b0, 32'h1234A5DD});
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, stall1);
    chk("post_reset_latency", lat, 2);

    repeat (3) @(negedge CLK);
    chk("resp_queue_drained", exp_q.size(), 0);
    chk("mem_queue_drained", mem_exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
